// File: rtl/radio_ctrl_arbiter_pkg.sv
// Shared constants and types for the radio control-port arbiter.
package radio_ctrl_arbiter_pkg;

    localparam int unsigned DATA_W = 64;
    localparam int unsigned STAT_W = 16;
    localparam int unsigned EC_BIT = 63;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_REQ  = 2'd1,
        ARB_RESP = 2'd2
    } arb_state_e;

    // One control beat as seen on a requester port.
    typedef struct packed {
        logic [DATA_W-1:0] tdata;
        logic              tlast;
    } ctrl_beat_t;

endpackage

// File: rtl/radio_ctrl_arbiter_rr_pick.sv
// Round-robin picker: first requesting port searching upward from last+1, with wrap.
module rr_pick #(
    parameter  int unsigned NUM_PORTS = 4,
    localparam int unsigned PW        = $clog2(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [PW-1:0]        last,
    output logic                 any,
    output logic [PW-1:0]        idx
);

    int unsigned cand;
    logic [PW-1:0] cand_idx;

    always_comb begin
        any      = 1'b0;
        idx      = '0;
        cand     = 0;
        cand_idx = '0;
        for (int unsigned off = 1; off <= NUM_PORTS; off++) begin
            cand = 32'(last) + off;
            if (cand >= NUM_PORTS) begin
                cand = cand - NUM_PORTS;
            end
            cand_idx = PW'(cand);
            if (!any && req[cand_idx]) begin
                any = 1'b1;
                idx = cand_idx;
            end
        end
    end

endmodule

// File: rtl/radio_ctrl_arbiter.sv
// Transaction-level round-robin arbiter sharing one radio control processor between requesters.
// Optional per-port completed-transaction counters are built when RADIO_CTRL_ARB_STATS_EN is defined.
module radio_ctrl_arbiter
    import radio_ctrl_arbiter_pkg::*;
#(
    parameter  int unsigned NUM_PORTS = 4,
    localparam int unsigned PW        = $clog2(NUM_PORTS)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          clear,
    input  logic [DATA_W*NUM_PORTS-1:0]   in_tdata,
    input  logic [NUM_PORTS-1:0]          in_tlast,
    input  logic [NUM_PORTS-1:0]          in_tvalid,
    output logic [NUM_PORTS-1:0]          in_tready,
    output logic [DATA_W-1:0]             ctrl_tdata,
    output logic                          ctrl_tlast,
    output logic                          ctrl_tvalid,
    input  logic                          ctrl_tready,
    input  logic [DATA_W-1:0]             resp_tdata,
    input  logic                          resp_tlast,
    input  logic                          resp_tvalid,
    output logic                          resp_tready,
    output logic [DATA_W*NUM_PORTS-1:0]   out_tdata,
    output logic [NUM_PORTS-1:0]          out_tlast,
    output logic [NUM_PORTS-1:0]          out_tvalid,
    input  logic [NUM_PORTS-1:0]          out_tready,
    output logic [PW-1:0]                 grant,
    output logic                          busy,
    output logic [STAT_W*NUM_PORTS-1:0]   stat_txn
);

    arb_state_e    state_q, state_d;
    logic [PW-1:0] grant_q, grant_d;
    logic [PW-1:0] last_q, last_d;
    logic          first_q, first_d;
    logic          done;
    logic          hdr_is_ec;
    logic          pick_any;
    logic [PW-1:0] pick_idx;
    ctrl_beat_t    beat [NUM_PORTS];
    ctrl_beat_t    sel;

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_unpack
        assign beat[i] = {in_tdata[DATA_W*i +: DATA_W], in_tlast[i]};
    end

    assign sel       = beat[grant_q];
    assign hdr_is_ec = sel.tdata[EC_BIT];

    rr_pick #(
        .NUM_PORTS (NUM_PORTS)
    ) u_rr_pick (
        .req  (in_tvalid),
        .last (last_q),
        .any  (pick_any),
        .idx  (pick_idx)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ARB_IDLE;
            grant_q <= '0;
            last_q  <= PW'(NUM_PORTS - 1);
            first_q <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            first_q <= first_d;
        end
    end

    // Next state and handshake steering; the granted port is held until its response completes
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        last_d      = last_q;
        first_d     = first_q;
        done        = 1'b0;
        in_tready   = '0;
        ctrl_tvalid = 1'b0;
        ctrl_tlast  = 1'b0;
        resp_tready = 1'b0;
        out_tvalid  = '0;

        unique case (state_q)
            ARB_IDLE: begin
                if (pick_any) begin
                    grant_d = pick_idx;
                    first_d = 1'b1;
                    state_d = ARB_REQ;
                end
            end
            ARB_REQ: begin
                ctrl_tvalid        = in_tvalid[grant_q];
                ctrl_tlast         = sel.tlast;
                in_tready[grant_q] = ctrl_tready;
                if (ctrl_tvalid && ctrl_tready) begin
                    first_d = 1'b0;
                    if (sel.tlast) begin
                        // A lone non-EC header carries no response
                        if (first_q && !hdr_is_ec) begin
                            done    = 1'b1;
                            state_d = ARB_IDLE;
                        end else begin
                            state_d = ARB_RESP;
                        end
                    end
                end
            end
            ARB_RESP: begin
                out_tvalid[grant_q] = resp_tvalid;
                resp_tready         = out_tready[grant_q];
                if (resp_tvalid && resp_tready && resp_tlast) begin
                    done    = 1'b1;
                    state_d = ARB_IDLE;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase

        if (done) begin
            last_d = grant_q;
        end

        if (clear) begin
            state_d = ARB_IDLE;
            grant_d = '0;
            last_d  = PW'(NUM_PORTS - 1);
            first_d = 1'b0;
            done    = 1'b0;
        end
    end

    assign ctrl_tdata = sel.tdata;
    assign out_tdata  = {NUM_PORTS{resp_tdata}};
    assign out_tlast  = {NUM_PORTS{resp_tlast}};
    assign grant      = grant_q;
    assign busy       = (state_q != ARB_IDLE);

`ifdef RADIO_CTRL_ARB_STATS_EN
    // Completed-transaction counters survive clear; only reset zeroes them
    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_stat
        logic [STAT_W-1:0] cnt_q;
        always_ff @(posedge clk) begin
            if (reset) begin
                cnt_q <= '0;
            end else if (done && (grant_q == PW'(i))) begin
                cnt_q <= cnt_q + STAT_W'(1);
            end
        end
        assign stat_txn[STAT_W*i +: STAT_W] = cnt_q;
    end
`else
    assign stat_txn = '0;
`endif

endmodule

// File: tb/tb_radio_ctrl_arbiter.sv
// Self-checking bench for radio_ctrl_arbiter: transaction-level reference model with randomized traffic.
module tb_radio_ctrl_arbiter;

    localparam int NP = 4;

    logic              clk = 1'b0;
    logic              reset, clear;
    logic [64*NP-1:0]  in_tdata;
    logic [NP-1:0]     in_tlast, in_tvalid, in_tready;
    logic [63:0]       ctrl_tdata;
    logic              ctrl_tlast, ctrl_tvalid, ctrl_tready;
    logic [63:0]       resp_tdata;
    logic              resp_tlast, resp_tvalid, resp_tready;
    logic [64*NP-1:0]  out_tdata;
    logic [NP-1:0]     out_tlast, out_tvalid, out_tready;
    logic [1:0]        grant;
    logic              busy;
    logic [16*NP-1:0]  stat_txn;

    radio_ctrl_arbiter #(.NUM_PORTS(NP)) dut (
        .clk         (clk),
        .reset       (reset),
        .clear       (clear),
        .in_tdata    (in_tdata),
        .in_tlast    (in_tlast),
        .in_tvalid   (in_tvalid),
        .in_tready   (in_tready),
        .ctrl_tdata  (ctrl_tdata),
        .ctrl_tlast  (ctrl_tlast),
        .ctrl_tvalid (ctrl_tvalid),
        .ctrl_tready (ctrl_tready),
        .resp_tdata  (resp_tdata),
        .resp_tlast  (resp_tlast),
        .resp_tvalid (resp_tvalid),
        .resp_tready (resp_tready),
        .out_tdata   (out_tdata),
        .out_tlast   (out_tlast),
        .out_tvalid  (out_tvalid),
        .out_tready  (out_tready),
        .grant       (grant),
        .busy        (busy),
        .stat_txn    (stat_txn)
    );

    always #5 clk = ~clk;

    // Reference model state: pending packets per port, RR pointer, completion counts
    bit          pend [NP];
    int          plen [NP];
    int          pos  [NP];
    logic [63:0] pdata [NP][4];
    int          exp_last;
    int          exp_cnt [NP];
    int          n_cmp = 0;
    int          n_fail = 0;

    function automatic int rr_ref(input logic [NP-1:0] m, input int last);
        for (int k = 1; k <= NP; k++) begin
            if (m[(last + k) % NP]) return (last + k) % NP;
        end
        return -1;
    endfunction

    function automatic logic [16*NP-1:0] exp_stat();
        logic [16*NP-1:0] s;
        s = '0;
`ifdef RADIO_CTRL_ARB_STATS_EN
        for (int i = 0; i < NP; i++) s[16*i +: 16] = 16'(exp_cnt[i]);
`endif
        return s;
    endfunction

    task automatic finish_sim();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    endtask

    task automatic new_pkt(input int p, input int len, input bit ec);
        for (int b = 0; b < 4; b++) pdata[p][b] = {$urandom, $urandom};
        pdata[p][0][63] = ec;
        plen[p] = len;
        pos[p]  = 0;
        pend[p] = 1'b1;
    endtask

    // Pending ports present their current beat; w is the granted port (-1 in idle), wv its valid
    task automatic drive_in(input int w, input bit wv);
        for (int i = 0; i < NP; i++) begin
            in_tvalid[i] = pend[i] && ((i != w) || wv);
            if (pend[i]) begin
                in_tdata[64*i +: 64] = pdata[i][pos[i]];
                in_tlast[i]          = (pos[i] == plen[i] - 1);
            end else begin
                in_tdata[64*i +: 64] = {$urandom, $urandom};
                in_tlast[i]          = 1'($urandom);
            end
        end
    endtask

    // Runs one arbitration round from an idle negedge until the granted transaction ends
    task automatic serve_one(input bit stall, input int rlen_in, input int clear_at, output int won);
        logic [NP-1:0] mask;
        logic [63:0]   rdata;
        logic [NP-1:0] exp_rdy;
        int            w, cyc, nresp, ridx;
        bit            sent, no_resp, wv;

        for (int i = 0; i < NP; i++) mask[i] = pend[i];
        w   = rr_ref(mask, exp_last);
        won = w;
        no_resp = 1'b0;

        drive_in(-1, 1'b1);
        ctrl_tready = 1'b1;
        resp_tvalid = 1'b0;
        out_tready  = '1;
        #1;
        n_cmp++;
        if (busy !== 1'b0 || in_tready !== '0 || ctrl_tvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_outputs: busy=%b in_tready=%b ctrl_tvalid=%b, required 0/0000/0", busy, in_tready, ctrl_tvalid);
        end
        n_cmp++;
        if (stat_txn !== exp_stat()) begin
            n_fail++;
            $display("FAIL stat_txn: got %h required %h", stat_txn, exp_stat());
        end
        @(negedge clk);
        n_cmp++;
        if (grant !== 2'(w) || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL grant: got grant=%0d busy=%b required grant=%0d busy=1", grant, busy, w);
        end

        sent = 1'b0;
        cyc  = 0;
        while (!sent) begin
            wv = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
            drive_in(w, wv);
            ctrl_tready = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
            resp_tvalid = 1'($urandom);
            resp_tdata  = {$urandom, $urandom};
            resp_tlast  = 1'($urandom);
            out_tready  = 4'($urandom);
            #1;
            exp_rdy = ctrl_tready ? 4'(1 << w) : 4'b0000;
            n_cmp++;
            if (ctrl_tvalid !== wv || in_tready !== exp_rdy || grant !== 2'(w)) begin
                n_fail++;
                $display("FAIL req_handshake: ctrl_tvalid=%b in_tready=%b grant=%0d required %b/%b/%0d",
                         ctrl_tvalid, in_tready, grant, wv, exp_rdy, w);
            end
            if (wv) begin
                n_cmp++;
                if (ctrl_tdata !== pdata[w][pos[w]] || ctrl_tlast !== (pos[w] == plen[w] - 1)) begin
                    n_fail++;
                    $display("FAIL ctrl_beat: got %h/%b required %h/%b", ctrl_tdata, ctrl_tlast,
                             pdata[w][pos[w]], (pos[w] == plen[w] - 1));
                end
            end
            n_cmp++;
            if (resp_tready !== 1'b0 || out_tvalid !== '0) begin
                n_fail++;
                $display("FAIL resp_blocked: resp_tready=%b out_tvalid=%b required 0/0000", resp_tready, out_tvalid);
            end
            if (wv && ctrl_tready) begin
                if (pos[w] == plen[w] - 1) begin
                    sent    = 1'b1;
                    no_resp = (plen[w] == 1) && !pdata[w][0][63];
                    pend[w] = 1'b0;
                end
                pos[w]++;
            end
            @(negedge clk);
            if (++cyc > 200) begin
                n_fail++;
                $display("FAIL req_timeout: packet on port %0d not accepted in 200 cycles", w);
                finish_sim();
            end
        end

        if (!no_resp) begin
            nresp = (rlen_in > 0) ? rlen_in : int'($urandom_range(1, 3));
            ridx  = 0;
            rdata = {$urandom, $urandom};
            cyc   = 0;
            while (ridx < nresp) begin
                drive_in(w, 1'b0);
                if (ridx == clear_at) begin
                    clear       = 1'b1;
                    resp_tvalid = 1'b1;
                    resp_tdata  = rdata;
                    resp_tlast  = 1'b0;
                    out_tready  = '1;
                    @(negedge clk);
                    clear = 1'b0;
                    #1;
                    n_cmp++;
                    if (busy !== 1'b0 || grant !== 2'd0) begin
                        n_fail++;
                        $display("FAIL clear_state: busy=%b grant=%0d required 0/0", busy, grant);
                    end
                    n_cmp++;
                    if (in_tready !== '0 || ctrl_tvalid !== 1'b0 || resp_tready !== 1'b0 || out_tvalid !== '0) begin
                        n_fail++;
                        $display("FAIL clear_handshake: in_tready=%b ctrl_tvalid=%b resp_tready=%b out_tvalid=%b required all 0",
                                 in_tready, ctrl_tvalid, resp_tready, out_tvalid);
                    end
                    n_cmp++;
                    if (stat_txn !== exp_stat()) begin
                        n_fail++;
                        $display("FAIL clear_stat: got %h required %h", stat_txn, exp_stat());
                    end
                    resp_tvalid = 1'b0;
                    exp_last    = NP - 1;
                    return;
                end
                resp_tvalid = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
                resp_tdata  = rdata;
                resp_tlast  = (ridx == nresp - 1);
                out_tready  = stall ? 4'($urandom) : 4'hF;
                ctrl_tready = 1'($urandom);
                #1;
                n_cmp++;
                if (out_tvalid !== (resp_tvalid ? 4'(1 << w) : 4'b0000) || resp_tready !== out_tready[w]) begin
                    n_fail++;
                    $display("FAIL resp_route: out_tvalid=%b resp_tready=%b required %b/%b", out_tvalid, resp_tready,
                             (resp_tvalid ? 4'(1 << w) : 4'b0000), out_tready[w]);
                end
                if (resp_tvalid) begin
                    n_cmp++;
                    if (out_tdata[64*w +: 64] !== rdata || out_tlast[w] !== resp_tlast) begin
                        n_fail++;
                        $display("FAIL resp_beat: got %h/%b required %h/%b", out_tdata[64*w +: 64], out_tlast[w],
                                 rdata, resp_tlast);
                    end
                end
                n_cmp++;
                if (in_tready !== '0 || ctrl_tvalid !== 1'b0 || busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL resp_phase: in_tready=%b ctrl_tvalid=%b busy=%b required 0000/0/1", in_tready, ctrl_tvalid, busy);
                end
                if (resp_tvalid && out_tready[w]) begin
                    ridx++;
                    rdata = {$urandom, $urandom};
                end
                @(negedge clk);
                if (++cyc > 200) begin
                    n_fail++;
                    $display("FAIL resp_timeout: response for port %0d not drained in 200 cycles", w);
                    finish_sim();
                end
            end
            resp_tvalid = 1'b0;
        end

        exp_last = w;
        exp_cnt[w]++;
        drive_in(-1, 1'b1);
        #1;
        n_cmp++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_after_txn: got %b required 0", busy);
        end
    endtask

    task automatic test_reset();
        reset       = 1'b1;
        clear       = 1'b0;
        in_tvalid   = 4'($urandom);
        ctrl_tready = 1'b1;
        resp_tvalid = 1'b1;
        out_tready  = '1;
        for (int i = 0; i < NP; i++) begin
            pend[i]    = 1'b0;
            exp_cnt[i] = 0;
        end
        exp_last = NP - 1;
        repeat (2) @(negedge clk);
        #1;
        n_cmp++;
        if (busy !== 1'b0 || grant !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_state: busy=%b grant=%0d required 0/0", busy, grant);
        end
        n_cmp++;
        if (in_tready !== '0 || ctrl_tvalid !== 1'b0 || resp_tready !== 1'b0 || out_tvalid !== '0) begin
            n_fail++;
            $display("FAIL reset_handshake: in_tready=%b ctrl_tvalid=%b resp_tready=%b out_tvalid=%b required all 0",
                     in_tready, ctrl_tvalid, resp_tready, out_tvalid);
        end
        n_cmp++;
        if (stat_txn !== '0) begin
            n_fail++;
            $display("FAIL reset_stat: got %h required 0", stat_txn);
        end
        reset       = 1'b0;
        in_tvalid   = '0;
        resp_tvalid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_ec_packet();
        int won;
        new_pkt(2, 3, 1'b1);
        serve_one(1'b0, 3, -1, won);
        n_cmp++;
        if (won != 2) begin
            n_fail++;
            $display("FAIL ec_port: model winner %0d required 2", won);
        end
    endtask

    task automatic test_rr_order();
        int won;
        int order [6] = '{0, 1, 3, 0, 1, 3};
        for (int r = 0; r < 2; r++) begin
            new_pkt(0, int'($urandom_range(1, 3)), 1'b1);
            new_pkt(1, int'($urandom_range(1, 3)), 1'b1);
            new_pkt(3, int'($urandom_range(1, 3)), 1'b1);
            for (int k = 0; k < 3; k++) begin
                serve_one(1'b0, 0, -1, won);
                n_cmp++;
                if (won != order[3*r + k]) begin
                    n_fail++;
                    $display("FAIL rr_order: round %0d got port %0d required %0d", 3*r + k, won, order[3*r + k]);
                end
            end
        end
    endtask

    task automatic test_no_resp();
        int won;
        new_pkt(1, 1, 1'b0);
        serve_one(1'b0, 0, -1, won);
        n_cmp++;
        if (stat_txn[31:16] !== exp_stat() >> 16 & 16'hFFFF) begin
            n_fail++;
            $display("FAIL no_resp_stat: got %h required %h", stat_txn[31:16], exp_stat() >> 16 & 16'hFFFF);
        end
    endtask

    task automatic test_back_to_back();
        int won;
        for (int r = 0; r < 3; r++) begin
            new_pkt(3, int'($urandom_range(1, 4)), 1'($urandom));
            serve_one(1'b0, 0, -1, won);
            n_cmp++;
            if (won != 3) begin
                n_fail++;
                $display("FAIL back_to_back: got port %0d required 3", won);
            end
        end
    endtask

    task automatic test_random_stall();
        int won;
        for (int r = 0; r < 30; r++) begin
            for (int p = 0; p < NP; p++) begin
                if (!pend[p] && ($urandom_range(0, 1) == 1)) new_pkt(p, int'($urandom_range(1, 4)), 1'($urandom));
            end
            if (!(pend[0] || pend[1] || pend[2] || pend[3])) new_pkt(int'($urandom_range(0, NP - 1)), 2, 1'b0);
            serve_one(1'b1, 0, -1, won);
        end
        // drain leftovers so later tests start from a known pending set
        while (pend[0] || pend[1] || pend[2] || pend[3]) serve_one(1'b1, 0, -1, won);
    endtask

    task automatic test_clear();
        int won;
        new_pkt(2, 2, 1'b1);
        serve_one(1'b0, 3, 1, won);
        new_pkt(2, 1, 1'b1);
        new_pkt(0, 1, 1'b1);
        serve_one(1'b0, 0, -1, won);
        n_cmp++;
        if (won != 0) begin
            n_fail++;
            $display("FAIL clear_rr_restart: got port %0d required 0", won);
        end
        serve_one(1'b0, 0, -1, won);
    endtask

    initial begin
        reset       = 1'b1;
        clear       = 1'b0;
        in_tdata    = '0;
        in_tlast    = '0;
        in_tvalid   = '0;
        ctrl_tready = 1'b0;
        resp_tdata  = '0;
        resp_tlast  = 1'b0;
        resp_tvalid = 1'b0;
        out_tready  = '0;
        @(negedge clk);
        test_reset();
        test_ec_packet();
        test_reset();
        test_rr_order();
        test_no_resp();
        test_back_to_back();
        test_random_stall();
        test_clear();
        test_reset();
        finish_sim();
    end

endmodule
